pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program counter for the single-issue RV32 core.
- Successor to the fixed 10-bit PC+4/branch counter, adding:
  - a stall input;
  - four redirect modes: relative branch, absolute JALR-style jump, relative call, return;
  - an internal return-address stack (RAS);
  - misalignment detection.
- Feeds the instruction-memory address and receives redirects from the execute stage.

Parameters:
- PC_WIDTH, 10: width of pc_out in bits; byte address.
- OFFSET_WIDTH, 20: width of the signed two's-complement jump_offset, in bytes.
- RESET_ADDR, 0: PC value after reset; must be a multiple of 4.
- RAS_DEPTH, 4: number of RAS entries; must be ≥1.

Ports:
- clk  in  1: clock; all state updates on the rising edge.
- reset  in  1: synchronous, active-high reset.
- stall  in  1: hold the PC; blocks redirect acceptance.
- redirect_valid  in  1: redirect request.
- redirect_ready  out  1: equal to ~stall (combinational). A redirect is accepted when valid & ready.
- redirect_mode  in  2: 00 relative branch, 01 absolute jump, 10 relative call, 11 return.
- jump_offset  in  OFFSET_WIDTH: signed byte offset.
- base_addr  in  PC_WIDTH: base register value for mode 01.
- pc_out  out  PC_WIDTH: current PC (registered).
- misaligned_err  out  1: one-cycle pulse when a redirect target is rejected.
- ras_underflow  out  1: one-cycle pulse on a return with an empty RAS.
- ras_empty  out  1: RAS count == 0 (combinational from count).
- ras_full  out  1: RAS count == RAS_DEPTH (combinational from count).

Behaviour:
- Reset, synchronous, highest priority:
  - pc_out = RESET_ADDR; RAS count = 0; misaligned_err = 0; ras_underflow = 0.
  - RAS contents are don't-care.
- Each edge, in priority order reset > stall > accepted redirect > sequential:
  - stall=1: pc_out holds; redirect ignored (requester holds it); RAS unchanged; pulses 0.
  - No redirect: pc_out <= pc_out + 4.
  - Redirect accepted: target computed from pc_out and inputs sampled in the same cycle; pc_out = target one cycle after acceptance.
- Arithmetic:
  - Offset sign-extended (or truncated) to PC_WIDTH.
  - All sums taken modulo 2^PC_WIDTH; wrap-around is silent.
- Targets by mode:
  - 00: pc_out + offset.
  - 01: (base_addr + offset) with bit0 forced to 0.
  - 10: pc_out + offset. Pushes pc_out+4 onto the RAS.
  - 11: popped RAS top; offset and base ignored.
- Alignment check:
  - If target[1:0] != 0, the redirect is rejected:
    - pc_out <= pc_out + 4; misaligned_err = 1 for that cycle.
    - No RAS push/pop occurs for a rejected call.
  - Return targets are always aligned.
- RAS is a circular LIFO:
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH; no error raised.
  - Pop when empty: target = pc_out + 4; ras_underflow = 1 for the cycle; count stays 0.
  - Push and pop never coincide (one mode per redirect).
- Pulse outputs are registered: they assert in the cycle after the accepting edge, aligned with the new pc_out.
- Reset asserted mid-sequence (including during stall or redirect) overrides everything on that edge.

Test Plan:
- Reset and sequential fetch, defaults: reset=1 one cycle, then run → pc_out 0, 4, 8, 12; ras_empty=1.
- Relative branches and wrap:
  - At pc=8, mode 00 offset 196 → 204; then offset 800 → 1004.
  - Then sequential → 1008 … 1020 → 0 (wrap).
  - Offset -8 at pc=16 → 8.
- Stall and redirect hold:
  - stall=1 for 3 cycles with redirect_valid=1 (offset 40) → pc_out constant, redirect_ready=0.
  - stall drops → pc_out = held pc + 40 next cycle.
- Call/return nesting:
  - At pc=20, call offset 100 → 120; at 120, call offset 40 → 160.
  - return → 124; return → 24.
  - Third return → pc_prev+4 with ras_underflow pulse, ras_empty=1.
- RAS overflow (RAS_DEPTH=4): 5 nested calls → ras_full=1; five returns → the four newest link addresses in LIFO order, then underflow on the fifth.
- Misalignment:
  - mode 00 offset 2 at pc=32 → pc_out 36, misaligned_err one cycle.
  - mode 01 base 0x41 offset 0 → 0x40 accepted.
  - mode 01 base 0x42 → rejected with pulse.
  - Misaligned call → RAS count unchanged.

Source files
------------

// File: rtl/pc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module : pc_unit_if
//  Brief  : Redirect handshake between the execute stage and the PC unit.
//  Rev    : 1.0
// ============================================================================
interface pc_unit_if #(
  parameter int PC_WIDTH     = 10,
  parameter int OFFSET_WIDTH = 20
);
  logic                    redirect_valid;
  logic                    redirect_ready;
  logic [1:0]              redirect_mode;
  logic [OFFSET_WIDTH-1:0] jump_offset;
  logic [PC_WIDTH-1:0]     base_addr;

  modport master (
    output redirect_valid,
    output redirect_mode,
    output jump_offset,
    output base_addr,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_mode,
    input  jump_offset,
    input  base_addr,
    output redirect_ready
  );
endinterface
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module : pc_unit
//  Brief  : RV32 program counter with redirects, return-address stack and
//           misalignment rejection.
//  Rev    : 1.0
// ============================================================================
module pc_unit #(
  parameter int PC_WIDTH     = 10,
  parameter int OFFSET_WIDTH = 20,
  parameter int RESET_ADDR   = 0,
  parameter int RAS_DEPTH    = 4
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                stall,
  pc_unit_if.slave                 redir,
  output logic [PC_WIDTH-1:0]      pc_out,
  output logic                     misaligned_err,
  output logic                     ras_underflow,
  output logic                     ras_empty,
  output logic                     ras_full
);

  localparam int                   c_PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int                   c_CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [c_PTR_W-1:0]   c_PTR_MAX = c_PTR_W'(RAS_DEPTH - 1);
  localparam logic [c_CNT_W-1:0]   c_CNT_MAX = c_CNT_W'(RAS_DEPTH);
  localparam logic [PC_WIDTH-1:0]  c_STEP    = PC_WIDTH'(4);
  localparam logic [1:0]           c_BRANCH  = 2'b00;
  localparam logic [1:0]           c_JUMP    = 2'b01;
  localparam logic [1:0]           c_CALL    = 2'b10;
  localparam logic [1:0]           c_RETURN  = 2'b11;

  logic [PC_WIDTH-1:0] r_pc;
  logic                r_mis;
  logic                r_unf;
  logic [PC_WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_CNT_W-1:0]  r_count;

  logic [PC_WIDTH-1:0] w_off;
  logic [PC_WIDTH-1:0] w_seq;
  logic [PC_WIDTH-1:0] w_target;
  logic [c_PTR_W-1:0]  w_top_idx;
  logic [c_PTR_W-1:0]  w_ptr_inc;
  logic                w_accept;
  logic                w_misaligned;
  logic                w_push;
  logic                w_pop;

  generate
    if (OFFSET_WIDTH >= PC_WIDTH) begin : g_off_trunc
      logic w_unused_hi;
      assign w_off       = redir.jump_offset[PC_WIDTH-1:0];
      assign w_unused_hi = ^{1'b0, redir.jump_offset};
    end else begin : g_off_sext
      assign w_off = {{(PC_WIDTH-OFFSET_WIDTH){redir.jump_offset[OFFSET_WIDTH-1]}},
                      redir.jump_offset};
    end
  endgenerate

  assign redir.redirect_ready = ~stall;
  assign w_accept             = redir.redirect_valid & ~stall;
  assign w_seq                = r_pc + c_STEP;
  assign ras_empty            = (r_count == '0);
  assign ras_full             = (r_count == c_CNT_MAX);

  // The write pointer names the next free slot; the top of stack sits just below it.
  assign w_top_idx = (r_wr_ptr == '0)      ? c_PTR_MAX : r_wr_ptr - c_PTR_W'(1);
  assign w_ptr_inc = (r_wr_ptr == c_PTR_MAX) ? '0      : r_wr_ptr + c_PTR_W'(1);

  always_comb begin
    w_target = w_seq;
    case (redir.redirect_mode)
      c_BRANCH: w_target = r_pc + w_off;
      c_JUMP:   w_target = (redir.base_addr + w_off) & ~PC_WIDTH'(1);
      c_CALL:   w_target = r_pc + w_off;
      c_RETURN: w_target = ras_empty ? w_seq : r_ras[w_top_idx];
      default:  w_target = w_seq;
    endcase
  end

  assign w_misaligned = (w_target[1:0] != 2'b00);
  assign w_push       = w_accept & ~w_misaligned & (redir.redirect_mode == c_CALL);
  assign w_pop        = w_accept & (redir.redirect_mode == c_RETURN) & ~ras_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= PC_WIDTH'(RESET_ADDR);
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_mis    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_mis <= 1'b0;
      r_unf <= 1'b0;
      if (!stall) begin
        if (w_accept && w_misaligned) begin
          r_pc  <= w_seq;
          r_mis <= 1'b1;
        end else if (w_accept) begin
          r_pc  <= w_target;
          r_unf <= ras_empty & (redir.redirect_mode == c_RETURN);
        end else begin
          r_pc <= w_seq;
        end

        // A full stack overwrites its oldest slot; the count just saturates.
        if (w_push) begin
          r_ras[r_wr_ptr] <= w_seq;
          r_wr_ptr        <= w_ptr_inc;
          if (r_count != c_CNT_MAX) r_count <= r_count + c_CNT_W'(1);
        end else if (w_pop) begin
          r_wr_ptr <= w_top_idx;
          r_count  <= r_count - c_CNT_W'(1);
        end
      end
    end
  end

  assign pc_out         = r_pc;
  assign misaligned_err = r_mis;
  assign ras_underflow  = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module : tb_pc_unit
//  Brief  : Directed plus randomized checks of pc_unit against a queue model.
//  Rev    : 1.0
// ============================================================================
module tb_pc_unit;

  localparam int c_PCW   = 10;
  localparam int c_OFFW  = 20;
  localparam int c_DEPTH = 4;
  localparam int c_MASK  = (1 << c_PCW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic stall;
  logic [c_PCW-1:0] pc_out;
  logic misaligned_err, ras_underflow, ras_empty, ras_full;

  pc_unit_if #(.PC_WIDTH(c_PCW), .OFFSET_WIDTH(c_OFFW)) bus ();

  pc_unit #(
    .PC_WIDTH(c_PCW), .OFFSET_WIDTH(c_OFFW), .RESET_ADDR(0), .RAS_DEPTH(c_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .redir(bus.slave),
    .pc_out(pc_out), .misaligned_err(misaligned_err),
    .ras_underflow(ras_underflow), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: PC as an integer, RAS as a queue whose back is the top.
  int m_pc  = 0;
  int m_err = 0;
  int m_unf = 0;
  int m_ras[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit st, input bit v,
                            input int mode, input int off, input int base);
    int t;
    bit und;
    m_err = 0;
    m_unf = 0;
    if (rst) begin
      m_pc = 0;
      m_ras.delete();
    end else if (st) begin
      // hold
    end else if (!v) begin
      m_pc = (m_pc + 4) & c_MASK;
    end else begin
      und = 0;
      case (mode)
        0, 2:    t = (m_pc + off) & c_MASK;
        1:       t = ((base + off) & c_MASK) & ~1;
        default: begin
          if (m_ras.size() == 0) begin
            t   = (m_pc + 4) & c_MASK;
            und = 1;
          end else begin
            t = m_ras[$];
          end
        end
      endcase
      if ((t & 3) != 0) begin
        m_pc  = (m_pc + 4) & c_MASK;
        m_err = 1;
      end else begin
        if (mode == 2) begin
          m_ras.push_back((m_pc + 4) & c_MASK);
          if (m_ras.size() > c_DEPTH) void'(m_ras.pop_front());
        end else if (mode == 3 && !und) begin
          void'(m_ras.pop_back());
        end
        m_unf = und;
        m_pc  = t;
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit st, input bit v,
                       input int mode, input int off, input int base);
    reset              = rst;
    stall              = st;
    bus.redirect_valid = v;
    bus.redirect_mode  = mode[1:0];
    bus.jump_offset    = off[c_OFFW-1:0];
    bus.base_addr      = base[c_PCW-1:0];
    #1;
    check_val("redirect_ready", {31'd0, bus.redirect_ready}, {31'd0, ~st});
    @(posedge clk);
    model_step(rst, st, v, mode, off, base);
    #1;
    check_val("pc_out", {22'd0, pc_out}, m_pc);
    check_val("misaligned_err", {31'd0, misaligned_err}, m_err);
    check_val("ras_underflow", {31'd0, ras_underflow}, m_unf);
    check_val("ras_empty", {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
    check_val("ras_full", {31'd0, ras_full}, {31'd0, m_ras.size() == c_DEPTH});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic redirect(input int mode, input int off, input int base);
    cycle(0, 0, 1, mode, off, base);
  endtask

  initial begin
    int r_mode, r_off, r_base;
    bit r_st, r_rst, r_v;

    cycle(1, 0, 0, 0, 0, 0);
    check_val("reset_pc_literal", {22'd0, pc_out}, 32'd0);
    idle(2);                         // 4, 8
    redirect(0, 196, 0);             // 204
    check_val("branch_204_literal", {22'd0, pc_out}, 32'd204);
    redirect(0, 800, 0);             // 1004
    idle(5);                         // 1008..1020, wrap to 0
    check_val("wrap_literal", {22'd0, pc_out}, 32'd0);
    idle(4);                         // 16
    redirect(0, -8, 0);              // 8

    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 40, 0);
    redirect(0, 40, 0);              // held pc + 40

    cycle(1, 0, 0, 0, 0, 0);
    idle(5);                         // 20
    redirect(2, 100, 0);             // 120
    redirect(2, 40, 0);              // 160
    redirect(3, 0, 0);               // 124
    redirect(3, 0, 0);               // 24
    redirect(3, 0, 0);               // underflow
    check_val("underflow_literal", {31'd0, ras_underflow}, 32'd1);

    for (int i = 0; i < 5; i++) redirect(2, 8, 0);
    for (int i = 0; i < 5; i++) redirect(3, 0, 0);

    cycle(1, 0, 0, 0, 0, 0);
    idle(8);                         // 32
    redirect(0, 2, 0);               // rejected -> 36
    redirect(1, 0, 'h41);            // 0x40
    redirect(1, 0, 'h42);            // rejected
    redirect(2, 6, 0);               // misaligned call, no push
    cycle(1, 1, 1, 2, 16, 0);        // reset wins over stall and redirect

    for (int i = 0; i < 400; i++) begin
      r_rst  = ($urandom_range(0, 99) < 2);
      r_st   = ($urandom_range(0, 99) < 20);
      r_v    = ($urandom_range(0, 99) < 60);
      r_mode = int'($urandom_range(0, 3));
      r_off  = int'($urandom_range(0, (1 << c_OFFW) - 1)) - (1 << (c_OFFW - 1));
      if ($urandom_range(0, 3) != 0) r_off = r_off & ~3;
      r_base = int'($urandom_range(0, c_MASK));
      cycle(r_rst, r_st, r_v, r_mode, r_off, r_base);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
